// File: rtl/m_unit_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// m_unit_sequencer_pkg
//   Shared definitions for the RV32M sequencer: func3 encodings, FSM state
//   encoding and small func3 decode helpers.
// ---------------------------------------------------------------------------
package m_unit_sequencer_pkg;

  localparam logic [2:0] FUNC3_MUL    = 3'b000;
  localparam logic [2:0] FUNC3_MULH   = 3'b001;
  localparam logic [2:0] FUNC3_MULHSU = 3'b010;
  localparam logic [2:0] FUNC3_MULHU  = 3'b011;
  localparam logic [2:0] FUNC3_DIV    = 3'b100;
  localparam logic [2:0] FUNC3_DIVU   = 3'b101;
  localparam logic [2:0] FUNC3_REM    = 3'b110;
  localparam logic [2:0] FUNC3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    M_ST_IDLE = 2'b00,
    M_ST_MUL  = 2'b01,
    M_ST_DIV  = 2'b10,
    M_ST_DONE = 2'b11
  } m_state_e;

  // func3[2] separates the divide class (DIV/DIVU/REM/REMU) from multiplies
  function automatic logic is_div_class(input logic [2:0] f3);
    return f3[2];
  endfunction

  // DIV and REM are the signed divide-class ops (func3[0] clear)
  function automatic logic is_signed_div(input logic [2:0] f3);
    return f3[2] & ~f3[0];
  endfunction

endpackage

// File: rtl/m_unit_sequencer_if.sv
// ---------------------------------------------------------------------------
// m_unit_sequencer_if
//   EX-stage <-> M-unit connection.
//   master (EX stage): drives ex_m_valid, ex_func3, ex_rs1, ex_rs2, flush;
//                      observes m_stall, m_result, m_result_valid, m_busy.
//   slave  (M unit)  : the reverse.
// ---------------------------------------------------------------------------
interface m_unit_sequencer_if #(parameter int XLEN = 32);

  logic            ex_m_valid;
  logic [2:0]      ex_func3;
  logic [XLEN-1:0] ex_rs1;
  logic [XLEN-1:0] ex_rs2;
  logic            flush;
  logic            m_stall;
  logic [XLEN-1:0] m_result;
  logic            m_result_valid;
  logic            m_busy;

  modport master (
    output ex_m_valid, ex_func3, ex_rs1, ex_rs2, flush,
    input  m_stall, m_result, m_result_valid, m_busy
  );

  modport slave (
    input  ex_m_valid, ex_func3, ex_rs1, ex_rs2, flush,
    output m_stall, m_result, m_result_valid, m_busy
  );

endinterface

// File: rtl/m_div_iter.sv
// ---------------------------------------------------------------------------
// m_div_iter
//   Unsigned XLEN-bit restoring divider, one quotient bit per step.
//   clk, rst_n       : clock, asynchronous active-low reset
//   load             : capture dividend/divisor, clear partial remainder
//   step             : commit one shift/subtract step
//   dividend/divisor : unsigned magnitudes
//   quotient/remainder : values after this cycle's step (combinational), so
//                        the owner can capture the final result on the same
//                        edge that commits the last step.
// ---------------------------------------------------------------------------
module m_div_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            step,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  logic [XLEN-1:0] quo_r;
  logic [XLEN-1:0] rem_r;
  logic [XLEN-1:0] dvs_r;
  logic [XLEN:0]   shifted_s;
  logic [XLEN:0]   diff_s;

  // One restoring step: shift next dividend bit in, trial-subtract divisor.
  // The partial remainder is below 2*divisor, so XLEN+1 bits hold it and the
  // top bit of the difference is the borrow.
  always_comb begin
    shifted_s = {rem_r, quo_r[XLEN-1]};
    diff_s    = shifted_s - {1'b0, dvs_r};
    if (!diff_s[XLEN]) begin
      quotient  = {quo_r[XLEN-2:0], 1'b1};
      remainder = diff_s[XLEN-1:0];
    end else begin
      quotient  = {quo_r[XLEN-2:0], 1'b0};
      remainder = shifted_s[XLEN-1:0];
    end
  end

  // Divider state: quotient bits shift in as dividend bits shift out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo_r <= {XLEN{1'b0}};
      rem_r <= {XLEN{1'b0}};
      dvs_r <= {XLEN{1'b0}};
    end else if (load) begin
      quo_r <= dividend;
      rem_r <= {XLEN{1'b0}};
      dvs_r <= divisor;
    end else if (step) begin
      quo_r <= quotient;
      rem_r <= remainder;
    end else begin
      quo_r <= quo_r;
      rem_r <= rem_r;
      dvs_r <= dvs_r;
    end
  end

endmodule

// File: rtl/m_unit_sequencer.sv
// ---------------------------------------------------------------------------
// m_unit_sequencer
//   RV32M sequencer in EX: fixed-latency multiply, iterative radix-2 divide.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : m_unit_sequencer_if.slave (ex_m_valid, ex_func3, ex_rs1, ex_rs2,
//           flush in; m_stall, m_result, m_result_valid, m_busy out)
//   Parameters: XLEN (operand width), MUL_CYCLES (accept-to-result, >=1).
//   Optional macro M_DIV_REUSE_EN: remember the last full divide's operands
//   and both results so DIV/REM (or DIVU/REMU) pairs finish in 2 cycles.
// ---------------------------------------------------------------------------
module m_unit_sequencer
  import m_unit_sequencer_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int MUL_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  m_unit_sequencer_if.slave     bus
);

  localparam int CNT_MAX = (XLEN > MUL_CYCLES) ? XLEN : MUL_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO     = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MUL_INIT = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_DIV_INIT = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  INT_MIN      = {1'b1, {(XLEN-1){1'b0}}};

  m_state_e        state_r, state_s;
  logic [CNT_W-1:0] count_r, count_s;
  logic [2:0]      func3_r;
  logic [XLEN-1:0] rs1_r, rs2_r;
  logic            q_neg_r, r_neg_r;
  logic [XLEN-1:0] result_r, result_s;
  logic            latch_s, div_load_s, div_step_s;
  logic            accept_s, sdiv_in_s, ovf_in_s, reuse_hit_s;
  logic [XLEN-1:0] reuse_result_s;
  logic [XLEN-1:0] div_dvd_s, div_dvs_s, div_quo_s, div_rem_s;
  logic [XLEN-1:0] fix_quo_s, fix_rem_s;

  // Full 2*XLEN product with per-op operand signedness, low or high half
  function automatic logic [XLEN-1:0] mul_result(input logic [2:0] f3,
                                                 input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
    logic            a_sgn, b_sgn;
    logic [2*XLEN-1:0] a_ext, b_ext, prod;
    a_sgn = (f3 == FUNC3_MULH) || (f3 == FUNC3_MULHSU);
    b_sgn = (f3 == FUNC3_MULH);
    a_ext = {{XLEN{a_sgn & a[XLEN-1]}}, a};
    b_ext = {{XLEN{b_sgn & b[XLEN-1]}}, b};
    prod  = a_ext * b_ext;
    return (f3 == FUNC3_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  endfunction

  // Two's-complement magnitude/negation helper
  function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic neg);
    return neg ? (~v + {{(XLEN-1){1'b0}}, 1'b1}) : v;
  endfunction

  assign accept_s  = bus.ex_m_valid && !bus.flush;
  assign sdiv_in_s = is_signed_div(bus.ex_func3);
  assign ovf_in_s  = sdiv_in_s && (bus.ex_rs1 == INT_MIN) && (&bus.ex_rs2);
  assign div_dvd_s = neg_if(bus.ex_rs1, sdiv_in_s & bus.ex_rs1[XLEN-1]);
  assign div_dvs_s = neg_if(bus.ex_rs2, sdiv_in_s & bus.ex_rs2[XLEN-1]);
  assign fix_quo_s = neg_if(div_quo_s, q_neg_r);
  assign fix_rem_s = neg_if(div_rem_s, r_neg_r);

  m_div_iter #(.XLEN(XLEN)) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (div_load_s),
    .step      (div_step_s),
    .dividend  (div_dvd_s),
    .divisor   (div_dvs_s),
    .quotient  (div_quo_s),
    .remainder (div_rem_s)
  );

`ifdef M_DIV_REUSE_EN
  logic            tag_valid_r, tag_signed_r, tag_set_s, tag_clear_s;
  logic [XLEN-1:0] tag_rs1_r, tag_rs2_r, tag_quo_r, tag_rem_r;

  assign reuse_hit_s    = tag_valid_r && is_div_class(bus.ex_func3) &&
                          (tag_rs1_r == bus.ex_rs1) && (tag_rs2_r == bus.ex_rs2) &&
                          (tag_signed_r == sdiv_in_s);
  assign reuse_result_s = bus.ex_func3[1] ? tag_rem_r : tag_quo_r;
  assign tag_set_s      = (state_r == M_ST_DIV) && !bus.flush && (count_r == CNT_ZERO);
  // A fresh divide start (non-hit) or an aborted divide drops the tag
  assign tag_clear_s    = ((state_r == M_ST_IDLE) && accept_s &&
                           is_div_class(bus.ex_func3) && !reuse_hit_s) ||
                          ((state_r == M_ST_DIV) && bus.flush);

  // Reuse tag and both results of the last completed full-path divide
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_valid_r  <= 1'b0;
      tag_signed_r <= 1'b0;
      tag_rs1_r    <= {XLEN{1'b0}};
      tag_rs2_r    <= {XLEN{1'b0}};
      tag_quo_r    <= {XLEN{1'b0}};
      tag_rem_r    <= {XLEN{1'b0}};
    end else if (tag_set_s) begin
      tag_valid_r  <= 1'b1;
      tag_signed_r <= is_signed_div(func3_r);
      tag_rs1_r    <= rs1_r;
      tag_rs2_r    <= rs2_r;
      tag_quo_r    <= fix_quo_s;
      tag_rem_r    <= fix_rem_s;
    end else if (tag_clear_s) begin
      tag_valid_r  <= 1'b0;
    end else begin
      tag_valid_r  <= tag_valid_r;
    end
  end
`else
  assign reuse_hit_s    = 1'b0;
  assign reuse_result_s = {XLEN{1'b0}};
`endif

  // Next-state, counter and result selection
  always_comb begin
    state_s    = state_r;
    count_s    = count_r;
    result_s   = result_r;
    latch_s    = 1'b0;
    div_load_s = 1'b0;
    div_step_s = 1'b0;
    case (state_r)
      M_ST_IDLE: begin
        if (accept_s) begin
          latch_s = 1'b1;
          if (!is_div_class(bus.ex_func3)) begin
            if (MUL_CYCLES == 1) begin
              state_s  = M_ST_DONE;
              result_s = mul_result(bus.ex_func3, bus.ex_rs1, bus.ex_rs2);
            end else begin
              state_s = M_ST_MUL;
              count_s = CNT_MUL_INIT;
            end
          end else if (reuse_hit_s) begin
            state_s  = M_ST_DONE;
            result_s = reuse_result_s;
          end else if (bus.ex_rs2 == {XLEN{1'b0}}) begin
            state_s  = M_ST_DONE;
            result_s = bus.ex_func3[1] ? bus.ex_rs1 : {XLEN{1'b1}};
          end else if (ovf_in_s) begin
            state_s  = M_ST_DONE;
            result_s = bus.ex_func3[1] ? {XLEN{1'b0}} : bus.ex_rs1;
          end else begin
            state_s    = M_ST_DIV;
            count_s    = CNT_DIV_INIT;
            div_load_s = 1'b1;
          end
        end else begin
          state_s = M_ST_IDLE;
        end
      end
      M_ST_MUL: begin
        // Result registers when the decremented count reaches zero, giving
        // MUL_CYCLES cycles from accept to the result cycle.
        if (bus.flush) begin
          state_s = M_ST_IDLE;
          count_s = CNT_ZERO;
        end else if (count_r == CNT_ONE) begin
          state_s  = M_ST_DONE;
          count_s  = CNT_ZERO;
          result_s = mul_result(func3_r, rs1_r, rs2_r);
        end else begin
          count_s = count_r - CNT_ONE;
        end
      end
      M_ST_DIV: begin
        if (bus.flush) begin
          state_s = M_ST_IDLE;
          count_s = CNT_ZERO;
        end else if (count_r == CNT_ZERO) begin
          div_step_s = 1'b1;
          state_s    = M_ST_DONE;
          result_s   = func3_r[1] ? fix_rem_s : fix_quo_s;
        end else begin
          div_step_s = 1'b1;
          count_s    = count_r - CNT_ONE;
        end
      end
      M_ST_DONE: begin
        state_s = M_ST_IDLE;
      end
      default: begin
        state_s = M_ST_IDLE;
        count_s = CNT_ZERO;
      end
    endcase
  end

  // FSM, counter, latched operands and result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= M_ST_IDLE;
      count_r  <= CNT_ZERO;
      func3_r  <= 3'b000;
      rs1_r    <= {XLEN{1'b0}};
      rs2_r    <= {XLEN{1'b0}};
      q_neg_r  <= 1'b0;
      r_neg_r  <= 1'b0;
      result_r <= {XLEN{1'b0}};
    end else begin
      state_r  <= state_s;
      count_r  <= count_s;
      result_r <= result_s;
      if (latch_s) begin
        func3_r <= bus.ex_func3;
        rs1_r   <= bus.ex_rs1;
        rs2_r   <= bus.ex_rs2;
        q_neg_r <= sdiv_in_s & (bus.ex_rs1[XLEN-1] ^ bus.ex_rs2[XLEN-1]);
        r_neg_r <= sdiv_in_s & bus.ex_rs1[XLEN-1];
      end else begin
        func3_r <= func3_r;
      end
    end
  end

  // Stall is gated by reset so every output reads zero while rst_n is low
  assign bus.m_stall        = rst_n && (((state_r == M_ST_IDLE) && accept_s) ||
                                        (state_r == M_ST_MUL) || (state_r == M_ST_DIV));
  assign bus.m_result       = result_r;
  assign bus.m_result_valid = (state_r == M_ST_DONE);
  assign bus.m_busy         = (state_r != M_ST_IDLE);

endmodule
